// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// S1 registers operands and opcode; S2 registers the result and status flags.
module alu_pipe #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [OP_W-1:0]   opcode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] q_out,
    output logic              c_out,
    output logic              z_out,
    output logic              n_out,
    output logic              v_out,
    output logic              illegal_out
);

    localparam int MSB = DATA_W - 1;
    localparam int XW  = DATA_W + 1;

    typedef enum logic [3:0] {
        OP_A   = 4'h0, OP_ADD = 4'h1, OP_ADC = 4'h2, OP_SUB = 4'h3,
        OP_SBB = 4'h4, OP_INC = 4'h5, OP_DEC = 4'h6, OP_B   = 4'h7,
        OP_OR  = 4'h8, OP_XOR = 4'h9, OP_AND = 4'hA, OP_NOT = 4'hB,
        OP_SHL = 4'hC, OP_SHR = 4'hD, OP_CMP = 4'hE, OP_ILL = 4'hF
    } op_e;

    localparam logic [XW-1:0] ONE_X = XW'(1);

    logic              s1_valid, s2_valid;
    logic [DATA_W-1:0] a_q, b_q;
    logic [OP_W-1:0]   op_q;
    logic              s1_adv, s2_adv, in_xfer;

    logic [XW-1:0]     ax, bx, r;
    logic [DATA_W-1:0] res, fsrc;
    logic              c_nx, v_nx, ill_nx, cmp;
    logic [31:0]       op_ext;
    op_e               op4;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_ready = !s1_valid || s2_adv;
    assign in_xfer  = in_valid && in_ready;

    function automatic logic ovf_add(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    function automatic logic ovf_sub(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ax     = {1'b0, a_q};
        bx     = {1'b0, b_q};
        r      = '0;
        res    = '0;
        c_nx   = 1'b0;
        v_nx   = 1'b0;
        ill_nx = 1'b0;
        cmp    = 1'b0;
        op_ext = 32'(op_q);
        op4    = op_e'(op_q[3:0]);

        case (op4)
            OP_A:   res = a_q;
            OP_ADD: begin r = ax + bx;         res = r[MSB:0]; c_nx = r[DATA_W]; v_nx = ovf_add(a_q[MSB], b_q[MSB], r[MSB]); end
            OP_ADC: begin r = ax + bx + ONE_X; res = r[MSB:0]; c_nx = r[DATA_W]; v_nx = ovf_add(a_q[MSB], b_q[MSB], r[MSB]); end
            OP_SUB: begin r = ax - bx;         res = r[MSB:0]; c_nx = r[DATA_W]; v_nx = ovf_sub(a_q[MSB], b_q[MSB], r[MSB]); end
            OP_SBB: begin r = ax - bx - ONE_X; res = r[MSB:0]; c_nx = r[DATA_W]; v_nx = ovf_sub(a_q[MSB], b_q[MSB], r[MSB]); end
            OP_INC: begin r = ax + ONE_X;      res = r[MSB:0]; c_nx = r[DATA_W]; v_nx = ovf_add(a_q[MSB], 1'b0, r[MSB]); end
            OP_DEC: begin r = ax - ONE_X;      res = r[MSB:0]; c_nx = r[DATA_W]; v_nx = ovf_sub(a_q[MSB], 1'b0, r[MSB]); end
            OP_B:   res = b_q;
            OP_OR:  res = a_q | b_q;
            OP_XOR: res = a_q ^ b_q;
            OP_AND: res = a_q & b_q;
            OP_NOT: res = ~a_q;
            OP_SHL: begin res = {a_q[MSB-1:0], 1'b0}; c_nx = a_q[MSB]; end
            OP_SHR: begin res = {1'b0, a_q[MSB:1]};   c_nx = a_q[0];   end
            // Compare keeps A as the result but reports the flags of A-B.
            OP_CMP: begin r = ax - bx; res = a_q; cmp = 1'b1; c_nx = r[DATA_W]; v_nx = ovf_sub(a_q[MSB], b_q[MSB], r[MSB]); end
            default: ill_nx = 1'b1;
        endcase

        if (op_ext > 32'd15) begin
            ill_nx = 1'b1;
        end
        if (ill_nx) begin
            res  = '0;
            c_nx = 1'b0;
            v_nx = 1'b0;
            cmp  = 1'b0;
        end

        fsrc = cmp ? r[MSB:0] : res;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            a_q      <= a_in;
            b_q      <= b_in;
            op_q     <= opcode;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid    <= 1'b0;
            q_out       <= '0;
            c_out       <= 1'b0;
            z_out       <= 1'b0;
            n_out       <= 1'b0;
            v_out       <= 1'b0;
            illegal_out <= 1'b0;
        end else if (s1_adv) begin
            s2_valid    <= 1'b1;
            q_out       <= res;
            c_out       <= c_nx;
            z_out       <= (fsrc == '0);
            n_out       <= fsrc[MSB];
            v_out       <= v_nx;
            illegal_out <= ill_nx;
        end else if (out_ready) begin
            s2_valid    <= 1'b0;
        end
    end

    assign out_valid = s2_valid;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vectors plus randomized traffic,
// scored against an integer-arithmetic reference model and an in-order queue.
module tb_alu_pipe;

    localparam int W    = 8;
    localparam int OPW  = 4;
    localparam int MAXU = 1 << W;
    localparam int SMAX = (1 << (W - 1)) - 1;
    localparam int SMIN = -(1 << (W - 1));

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]   a_in, b_in, q_out;
    logic [OPW-1:0] opcode;
    logic           c_out, z_out, n_out, v_out, illegal_out;

    alu_pipe #(.DATA_W(W), .OP_W(OPW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .q_out(q_out), .c_out(c_out), .z_out(z_out), .n_out(n_out),
        .v_out(v_out), .illegal_out(illegal_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic c, z, n, v, ill;
        int acc_cyc;
        int stall_at;
    } exp_t;

    exp_t          sb[$];
    exp_t          pend;
    int            n_vec = 0, n_err = 0, cyc = 0, stall_cnt = 0;
    bit            accepted, hold_pending, rand_ready;
    logic [W+5:0]  snap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic on the operand values.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
        exp_t e;
        int ua, ub, sa, sbv, r, sr;
        bit arith, cmp;
        logic [W-1:0] fl;
        e = '{default: 0};
        ua = int'(a); ub = int'(b);
        sa = $signed(a); sbv = $signed(b);
        r = 0; sr = 0; arith = 0; cmp = 0;
        case (op)
            4'h0: e.q = a;
            4'h1: begin r = ua + ub;     sr = sa + sbv;     arith = 1; end
            4'h2: begin r = ua + ub + 1; sr = sa + sbv + 1; arith = 1; end
            4'h3: begin r = ua - ub;     sr = sa - sbv;     arith = 1; end
            4'h4: begin r = ua - ub - 1; sr = sa - sbv - 1; arith = 1; end
            4'h5: begin r = ua + 1;      sr = sa + 1;       arith = 1; end
            4'h6: begin r = ua - 1;      sr = sa - 1;       arith = 1; end
            4'h7: e.q = b;
            4'h8: e.q = a | b;
            4'h9: e.q = a ^ b;
            4'hA: e.q = a & b;
            4'hB: e.q = ~a;
            4'hC: begin r = ua * 2; e.q = r[W-1:0]; e.c = (r >= MAXU); end
            4'hD: begin r = ua / 2; e.q = r[W-1:0]; e.c = ((ua % 2) == 1); end
            4'hE: begin r = ua - ub; sr = sa - sbv; arith = 1; cmp = 1; end
            default: e.ill = 1'b1;
        endcase
        if (arith) begin
            e.c = (r < 0) || (r >= MAXU);
            e.v = (sr > SMAX) || (sr < SMIN);
            e.q = cmp ? a : r[W-1:0];
        end
        fl  = cmp ? r[W-1:0] : e.q;
        e.z = (fl == '0);
        e.n = fl[W-1];
        return e;
    endfunction

    // One clock: inputs are already driven; sample 1ns after the falling edge.
    task automatic cycle();
        exp_t e;
        if (rand_ready) out_ready = ($urandom_range(3) != 0);
        #1;
        check("in_ready", in_ready, (sb.size() < 2) || out_ready);
        if (sb.size() == 0) check("idle_valid", out_valid, 0);
        if (hold_pending)
            check("hold_stable", {out_valid, q_out, c_out, z_out, n_out, v_out, illegal_out}, snap);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", out_valid, 0);
            end else begin
                e = sb.pop_front();
                check("q", q_out, e.q);
                check("c", c_out, e.c);
                check("z", z_out, e.z);
                check("n", n_out, e.n);
                check("v", v_out, e.v);
                check("illegal", illegal_out, e.ill);
                if (e.stall_at == stall_cnt) check("latency", cyc - e.acc_cyc, 2);
            end
        end
        hold_pending = out_valid && !out_ready;
        snap = {out_valid, q_out, c_out, z_out, n_out, v_out, illegal_out};
        accepted = in_valid && in_ready;
        if (accepted) begin
            pend.acc_cyc  = cyc;
            pend.stall_at = stall_cnt;
            sb.push_back(pend);
        end
        if (!out_ready) stall_cnt++;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op, input exp_t e);
        bit done = 0;
        in_valid = 1'b1; a_in = a; b_in = b; opcode = op; pend = e;
        for (int i = 0; i < 64 && !done; i++) begin
            cycle();
            done = accepted;
        end
        check("accept_timeout", done, 1);
        in_valid = 1'b0;
    endtask

    task automatic sendm(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
        send(a, b, op, model(a, b, op));
    endtask

    task automatic sendx(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                         input logic [W-1:0] q, input logic c, input logic z, input logic n,
                         input logic v, input logic ill);
        exp_t e;
        e = '{q: q, c: c, z: z, n: n, v: v, ill: ill, acc_cyc: 0, stall_at: 0};
        send(a, b, op, e);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic drain();
        in_valid = 1'b0;
        rand_ready = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() > 0; i++) cycle();
        check("drain_left", sb.size(), 0);
    endtask

    initial begin
        int start, taken;
        logic [W-1:0] bp_a[3];
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; rand_ready = 1'b0;
        a_in = '0; b_in = '0; opcode = '0; hold_pending = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_outputs", {q_out, c_out, z_out, n_out, v_out, illegal_out}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Directed vectors with hand-derived expectations.
        sendx(8'hFF, 8'h01, 4'h1, 8'h00, 1, 1, 0, 0, 0);
        sendx(8'h7F, 8'h01, 4'h1, 8'h80, 0, 0, 1, 1, 0);
        sendx(8'h10, 8'h20, 4'h3, 8'hF0, 1, 0, 1, 0, 0);
        sendx(8'h05, 8'h05, 4'hE, 8'h05, 0, 1, 0, 0, 0);
        sendx(8'h81, 8'h00, 4'hC, 8'h02, 1, 0, 0, 0, 0);
        sendx(8'h3C, 8'h99, 4'hF, 8'h00, 0, 1, 0, 0, 1);
        sendx(8'h01, 8'h00, 4'hD, 8'h00, 1, 1, 0, 0, 0);
        sendx(8'h7F, 8'h00, 4'h5, 8'h80, 0, 0, 1, 1, 0);
        sendx(8'h80, 8'h00, 4'h6, 8'h7F, 0, 0, 0, 1, 0);
        sendx(8'h00, 8'h00, 4'h6, 8'hFF, 1, 0, 1, 0, 0);
        sendx(8'h80, 8'h01, 4'hE, 8'h80, 0, 0, 0, 1, 0);
        drain();

        // Back-to-back stream: one accept per clock, results in order.
        start = cyc;
        for (int i = 0; i < 10; i++) sendm(W'(i * 29 + 3), W'(i * 7 + 200), 4'h1);
        check("stream_rate", cyc - start, 10);
        drain();

        // Backpressure: 4 stalled cycles, 3 offered, only 2 fit.
        for (int i = 0; i < 3; i++) bp_a[i] = W'($urandom);
        out_ready = 1'b0;
        taken = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = (taken < 3);
            a_in = bp_a[taken < 3 ? taken : 2]; b_in = 8'h11; opcode = 4'h2;
            pend = model(a_in, b_in, opcode);
            cycle();
            if (accepted) taken++;
        end
        check("bp_taken", taken, 2);
        #1;
        check("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
        sendm(bp_a[2], 8'h11, 4'h2);
        drain();

        // Randomized traffic with random consumer stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            sendm(W'($urandom), W'($urandom), 4'($urandom_range(15)));
            if ($urandom_range(3) == 0) idle(1);
        end
        drain();

        // Reset with both stages full: everything clears at once.
        out_ready = 1'b0;
        sendm(8'h12, 8'h34, 4'h1);
        sendm(8'h56, 8'h78, 4'h9);
        #1;
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_in_ready", in_ready, 1);
        check("async_rst_outputs", {q_out, c_out, z_out, n_out, v_out, illegal_out}, 0);
        sb.delete();
        hold_pending = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        idle(5);
        sendx(8'h01, 8'h02, 4'h1, 8'h03, 0, 0, 0, 0, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
